sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive inst-side losses before inst gets priority; legal range 1..7.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-003 clk  in  1  rising-edge clock, the only clock.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 inst_req, inst_wr  in  1 each  inst-side request valid and write flag.
REQ-006 inst_size  in  2  inst-side transfer size: 0 byte, 1 half, 2 word; 3 is treated as word.
REQ-007 inst_addr, inst_wdata  in  32 each  inst-side byte address and write data.
REQ-008 inst_addr_ok, inst_data_ok  out  1 each  inst-side request accepted, and response valid.
REQ-009 inst_rdata  out  32  inst-side read data.
REQ-010 data_req, data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata SHALL be the data-side equivalents with the same widths and meanings.
REQ-011 sram_en  out  1  shared SRAM enable.
REQ-012 sram_wen  out  4  shared SRAM byte write enables.
REQ-013 sram_addr, sram_wdata  out  32 each  shared SRAM address and write data.
REQ-014 sram_rdata  in  32  shared SRAM read data; valid one cycle after sram_en.

Function
REQ-015 Grant SHALL be combinational: at most one of inst_addr_ok or data_addr_ok is high per cycle.
- An addr_ok is only high when the matching req is high.
REQ-016 Default priority SHALL be data over inst.
- When starve_cnt == STARVE_LIMIT and inst_req is high, inst SHALL win.
REQ-017 starve_cnt (3 bits, saturating) SHALL increment when inst_req is high and data is granted.
- It SHALL clear when inst is granted or inst_req is low.
REQ-018 On a grant in cycle N, sram_en SHALL be 1 and the SRAM fields SHALL come from the winner:
- sram_addr = {addr[31:2], 2'b00};
- sram_wdata = wdata, passed unchanged (the master pre-replicates bytes/halves).
REQ-019 sram_wen SHALL be 0 for reads. For writes:
- byte: 4'b0001 << addr[1:0];
- half: 4'b0011 << {addr[1], 1'b0} (addr[0] ignored);
- word: 4'b1111 (addr[1:0] ignored).
REQ-020 Response tracking SHALL use a 3-state FSM: IDLE, RESP_INST, RESP_DATA.
- The next state is RESP_x when x is granted this cycle, else IDLE; the transition applies from every state.
REQ-021 In RESP_x, x_data_ok SHALL be 1 for exactly one cycle, and x_rdata SHALL equal sram_rdata.
- For writes, data_ok also pulses; rdata is don't-care.
REQ-022 Latency SHALL be exactly 1 cycle from addr_ok to data_ok.
- Back-to-back grants SHALL be sustained at one per cycle, including alternating owners.
REQ-023 When no grant occurs, sram_en SHALL be 0 and sram_wen SHALL be 0.
REQ-024 Both rdata outputs SHALL be driven with sram_rdata at all times.
- Requesters qualify rdata with their own data_ok.
REQ-025 Simultaneous events: a response to one side and a grant to the other in the same cycle SHALL both occur.

Reset
REQ-026 While resetn = 0: state = IDLE, starve_cnt = 0, all addr_ok/data_ok = 0, sram_en = 0, sram_wen = 0.
REQ-027 Reset is asynchronous: asserting resetn mid-transaction SHALL drop any pending data_ok; no response is delivered after deassertion.
REQ-028 In the first cycle after deassertion, the block SHALL accept requests normally.

Structure
REQ-029 A shared package/header SHALL hold the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state encodings.
REQ-030 The byte-enable generation SHALL be a sub-module sram_wen_gen (inputs wr, size, addr[1:0]; output wen[3:0]), instantiated once after the winner mux.

Verification
REQ-031 Data read at 0x1000 only -> data_addr_ok = 1 in cycle N, sram_en = 1, sram_addr = 0x1000; data_data_ok = 1 in N+1 with data_rdata = SRAM content; inst_data_ok stays 0.
REQ-032 inst_req and data_req held high for 6 cycles, STARVE_LIMIT = 4 -> grants D,D,D,D,I,D; starve_cnt returns to 0 after the inst grant.
REQ-033 Data byte write at 0x1003, then half write at 0x1002, then word write at 0x1001 -> sram_wen = 1000, 1100, 1111; sram_addr = 0x1000 each time.
REQ-034 Alternating grants I,D,I in consecutive cycles -> data_ok pulses I,D,I one cycle later, each exactly one cycle wide and never overlapping.
REQ-035 resetn pulled low in the cycle after an inst grant -> no inst_data_ok; all outputs 0 during reset; a request in the first post-reset cycle is granted.
REQ-036 No requests for 10 cycles -> sram_en = 0, sram_wen = 0, state stays IDLE, no data_ok pulses.

Source files
------------

// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: transfer sizes and response FSM states.
package sram_port_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRespInst = 2'd1,
        StRespData = 2'd2
    } resp_state_e;

endpackage

// File: rtl/sram_wen_gen.sv
// Byte write-enable generation for one SRAM access; reads produce no enables.
module sram_wen_gen
    import sram_port_arbiter_pkg::*;
(
    input  logic       wr,
    input  logic [1:0] size,
    input  logic [1:0] addr,
    output logic [3:0] wen
);

    always_comb begin
        wen = 4'b0000;
        if (wr) begin
            case (size)
                SZ_BYTE: wen = 4'b0001 << addr;
                SZ_HALF: wen = 4'b0011 << {addr[1], 1'b0};
                default: wen = 4'b1111;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates inst/data masters onto one SRAM port: data-first with an inst starvation guard,
// fixed one-cycle response latency tracked by a small FSM.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [2:0] Limit = 3'(STARVE_LIMIT);

    resp_state_e state;
    logic [2:0]  starve_cnt;
    logic        grant_inst;
    logic        grant_data;
    logic        win_wr;
    logic [1:0]  win_size;
    logic [31:0] win_addr;

    // Grants are gated by resetn so nothing is accepted while reset is asserted.
    assign grant_inst = resetn & inst_req & (~data_req | (starve_cnt == Limit));
    assign grant_data = resetn & data_req & ~grant_inst;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    always_comb begin
        win_wr     = grant_inst ? inst_wr    : (grant_data & data_wr);
        win_size   = grant_inst ? inst_size  : data_size;
        win_addr   = grant_inst ? inst_addr  : data_addr;
        sram_wdata = grant_inst ? inst_wdata : data_wdata;
    end

    assign sram_en   = grant_inst | grant_data;
    assign sram_addr = {win_addr[31:2], 2'b00};

    sram_wen_gen u_wen_gen (
        .wr   (win_wr),
        .size (win_size),
        .addr (win_addr[1:0]),
        .wen  (sram_wen)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= StIdle;
            starve_cnt <= 3'd0;
        end else begin
            if (grant_inst) begin
                state <= StRespInst;
            end else if (grant_data) begin
                state <= StRespData;
            end else begin
                state <= StIdle;
            end
            if (inst_req && grant_data) begin
                starve_cnt <= (starve_cnt == 3'd7) ? 3'd7 : starve_cnt + 3'd1;
            end else begin
                starve_cnt <= 3'd0;
            end
        end
    end

    assign inst_data_ok = (state == StRespInst);
    assign data_data_ok = (state == StRespData);
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model of arbitration, byte lanes and a word-addressed memory.
module tb_sram_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata;

    sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench-side SRAM, driven by the DUT's SRAM port; read data appears one cycle later.
    logic [31:0] sram_mem [16];
    always @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 16; i++) sram_mem[i] <= 32'h0;
            sram_rdata <= 32'h0;
        end else if (sram_en) begin
            if (sram_wen == 4'b0000) begin
                sram_rdata <= sram_mem[sram_addr[5:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wen[b]) sram_mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- reference model ----------------
    int          m_losses;
    int          m_pend;      // 0 none, 1 inst, 2 data
    logic        m_pend_rd;
    logic [31:0] m_pend_data;
    logic [31:0] m_mem [16];

    function automatic logic [3:0] exp_wen(input logic wr, input logic [1:0] sz,
                                           input logic [1:0] off);
        int v;
        if (!wr) return 4'h0;
        if (sz == 2'd0) v = 1 << off;
        else if (sz == 2'd1) v = 3 << (off & 2'd2);
        else v = 15;
        return 4'(v);
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            check("rst_inst_addr_ok", inst_addr_ok, 0);
            check("rst_data_addr_ok", data_addr_ok, 0);
            check("rst_inst_data_ok", inst_data_ok, 0);
            check("rst_data_data_ok", data_data_ok, 0);
            check("rst_sram_en", sram_en, 0);
            check("rst_sram_wen", sram_wen, 0);
            m_losses = 0;
            m_pend   = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
        end else begin
            logic iw, dw, wr;
            logic [1:0] sz;
            logic [31:0] a, wd;
            logic [3:0] we;
            iw = inst_req && (!data_req || m_losses == LIMIT);
            dw = data_req && !iw;
            check("inst_addr_ok", inst_addr_ok, iw);
            check("data_addr_ok", data_addr_ok, dw);
            check("inst_data_ok", inst_data_ok, m_pend == 1);
            check("data_data_ok", data_data_ok, m_pend == 2);
            if (m_pend == 1 && m_pend_rd) check("inst_rdata", inst_rdata, m_pend_data);
            if (m_pend == 2 && m_pend_rd) check("data_rdata", data_rdata, m_pend_data);
            if (iw || dw) begin
                wr = iw ? inst_wr    : data_wr;
                sz = iw ? inst_size  : data_size;
                a  = iw ? inst_addr  : data_addr;
                wd = iw ? inst_wdata : data_wdata;
                we = exp_wen(wr, sz, a[1:0]);
                check("sram_en", sram_en, 1);
                check("sram_addr", sram_addr, a & 32'hFFFF_FFFC);
                check("sram_wdata", sram_wdata, wd);
                check("sram_wen", sram_wen, we);
                if (wr) begin
                    for (int b = 0; b < 4; b++)
                        if (we[b]) m_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    m_pend_data = m_mem[a[5:2]];
                end
                m_pend_rd = !wr;
            end else begin
                check("idle_sram_en", sram_en, 0);
                check("idle_sram_wen", sram_wen, 0);
            end
            m_pend = iw ? 1 : (dw ? 2 : 0);
            if (inst_req && dw) m_losses = (m_losses >= 7) ? 7 : m_losses + 1;
            else m_losses = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic r, input logic w, input logic [1:0] s,
                            input logic [31:0] a, input logic [31:0] d);
        inst_req = r; inst_wr = w; inst_size = s; inst_addr = a; inst_wdata = d;
    endtask

    task automatic set_data(input logic r, input logic w, input logic [1:0] s,
                            input logic [31:0] a, input logic [31:0] d);
        data_req = r; data_wr = w; data_size = s; data_addr = a; data_wdata = d;
    endtask

    task automatic clear_reqs();
        set_inst(0, 0, 0, 32'h0, 32'h0);
        set_data(0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [5:0]  g;
        logic [4:0]  io, dok, iok;
        logic [3:0]  w [3];
        logic [31:0] ad [3];
        int          pulses;

        resetn = 1'b0;
        clear_reqs();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        // Idle: nothing happens for 10 cycles.
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            #2;
            check("idle_en_lit", sram_en, 0);
            pulses += int'(inst_data_ok) + int'(data_data_ok);
        end
        check("idle_pulses", pulses, 0);

        // Data read at 0x1000 after a word write.
        step(); set_data(1, 1, 2'd2, 32'h1000, 32'hCAFE_F00D); #2;
        step(); set_data(1, 0, 2'd2, 32'h1000, 32'h0); #2;
        check("rd_addr_ok_lit", data_addr_ok, 1);
        check("rd_sram_addr_lit", sram_addr, 32'h1000);
        step(); clear_reqs(); #2;
        check("rd_data_ok_lit", data_data_ok, 1);
        check("rd_rdata_lit", data_rdata, 32'hCAFE_F00D);
        check("rd_inst_ok_lit", inst_data_ok, 0);

        // Both sides requesting for 6 cycles: D,D,D,D,I,D.
        step(); #2;
        for (int i = 0; i < 6; i++) begin
            step();
            set_inst(1, 0, 2'd2, 32'h1010, 32'h0);
            set_data(1, 0, 2'd2, 32'h1020, 32'h0);
            #2;
            g[i] = inst_addr_ok;
        end
        check("starve_pattern_lit", {26'h0, g}, 32'b010000);
        step(); clear_reqs(); #2;
        step(); set_inst(1, 0, 2'd2, 32'h1010, 32'h0); set_data(1, 0, 2'd2, 32'h1020, 32'h0); #2;
        check("starve_cleared_lit", data_addr_ok, 1);

        // Byte, half, word writes at unaligned addresses.
        step(); clear_reqs(); #2;
        step(); #2;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 0) set_data(1, 1, 2'd0, 32'h1003, 32'hAAAA_AAAA);
            if (i == 1) set_data(1, 1, 2'd1, 32'h1002, 32'hBBBB_BBBB);
            if (i == 2) set_data(1, 1, 2'd2, 32'h1001, 32'h1234_5678);
            #2;
            w[i]  = sram_wen;
            ad[i] = sram_addr;
        end
        check("wen_byte_lit", w[0], 4'b1000);
        check("wen_half_lit", w[1], 4'b1100);
        check("wen_word_lit", w[2], 4'b1111);
        check("wr_addr0_lit", ad[0], 32'h1000);
        check("wr_addr2_lit", ad[2], 32'h1000);

        // Alternating owners I,D,I.
        step(); clear_reqs(); #2;
        step(); #2;
        for (int k = 0; k < 5; k++) begin
            step();
            clear_reqs();
            if (k == 0 || k == 2) set_inst(1, 0, 2'd2, 32'h1004, 32'h0);
            if (k == 1) set_data(1, 0, 2'd2, 32'h1008, 32'h0);
            #2;
            io[k]  = inst_addr_ok;
            iok[k] = inst_data_ok;
            dok[k] = data_data_ok;
        end
        check("alt_grant_lit", {27'h0, io}, 32'b00101);
        check("alt_inst_ok_lit", {27'h0, iok}, 32'b01010);
        check("alt_data_ok_lit", {27'h0, dok}, 32'b00100);

        // Reset asserted the cycle after an inst grant drops the response.
        step(); clear_reqs(); set_inst(1, 0, 2'd2, 32'h1000, 32'h0); #2;
        step(); resetn = 1'b0; set_data(1, 0, 2'd2, 32'h1000, 32'h0); #2;
        check("rst_no_resp_lit", inst_data_ok, 0);
        check("rst_no_grant_lit", inst_addr_ok | data_addr_ok, 0);
        step(); #2;
        step(); resetn = 1'b1; clear_reqs(); set_inst(1, 0, 2'd2, 32'h1004, 32'h0); #2;
        check("post_rst_grant_lit", inst_addr_ok, 1);
        step(); clear_reqs(); #2;
        check("post_rst_resp_lit", inst_data_ok, 1);

        // Randomized traffic; the negedge model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            step();
            set_inst($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                     2'($urandom_range(0, 3)), 32'h1000 + $urandom_range(0, 63), $urandom);
            set_data($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1,
                     2'($urandom_range(0, 3)), 32'h1000 + $urandom_range(0, 63), $urandom);
        end
        step(); clear_reqs();
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
